// File: rtl/main_control_fsm.sv
// Multi-cycle main control FSM (FETCH/DECODE/EXEC/MEM/WB) producing ALUop/function_code and datapath strobes.
// Optional feature: define ILLEGAL_OP_TRAP_EN to trap on illegal opcodes instead of executing them as NOP.
module main_control_fsm #(
   parameter int MEM_WAIT_MAX = 15
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        run,
   input  logic [31:0] instr,
   input  logic        mem_ready,
   output logic [1:0]  ALUop,
   output logic [5:0]  function_code,
   output logic        mem_read,
   output logic        mem_write,
   output logic        ir_write,
   output logic        pc_write,
   output logic        pc_write_cond,
   output logic        reg_write,
   output logic        alu_src,
   output logic        reg_dst,
   output logic        mem_to_reg,
   output logic [2:0]  state_out,
   output logic        instr_done,
   output logic        mem_timeout
);

   typedef enum logic [2:0] {
      S_IDLE = 3'd0, S_FETCH = 3'd1, S_DECODE = 3'd2, S_EXEC = 3'd3,
      S_MEM = 3'd4, S_WB = 3'd5, S_TRAP = 3'd6
   } state_t;

   typedef enum logic [2:0] {
      C_NOP = 3'd0, C_R = 3'd1, C_LW = 3'd2, C_SW = 3'd3,
      C_BEQ = 3'd4, C_I = 3'd5, C_ILL = 3'd6
   } cls_t;

   localparam logic [7:0] WAIT_LAST = 8'(MEM_WAIT_MAX - 1);

   state_t     state_r, state_s, fetch_or_idle_s;
   cls_t       cls_r;
   logic [7:0] wait_cnt_r;
   logic       mem_timeout_r;
   logic       mem_phase_s, timeout_hit_s;

   function automatic cls_t decode_class(input logic [5:0] op);
      case (op)
         6'b000000: return C_R;
         6'b100011: return C_LW;
         6'b101011: return C_SW;
         6'b000100: return C_BEQ;
         6'b001000, 6'b001001, 6'b001100, 6'b001101: return C_I;
         default:   return C_ILL;
      endcase
   endfunction

   assign mem_phase_s   = (state_r == S_FETCH) || (state_r == S_MEM);
   // Timeout fires on the MEM_WAIT_MAX-th consecutive wait cycle unless memory answers that cycle.
   assign timeout_hit_s = mem_phase_s && !mem_ready && (wait_cnt_r == WAIT_LAST);
   assign fetch_or_idle_s = run ? S_FETCH : S_IDLE;

   // Next-state decode.
   always_comb begin
      state_s = state_r;
      case (state_r)
         S_IDLE:   if (run) state_s = S_FETCH; else state_s = S_IDLE;
         S_FETCH: begin
            if (mem_ready)          state_s = S_DECODE;
            else if (timeout_hit_s) state_s = S_IDLE;
            else                    state_s = S_FETCH;
         end
         S_DECODE: state_s = S_EXEC;
         S_EXEC: begin
            case (cls_r)
               C_R, C_I:   state_s = S_WB;
               C_LW, C_SW: state_s = S_MEM;
               C_BEQ:      state_s = fetch_or_idle_s;
`ifdef ILLEGAL_OP_TRAP_EN
               default:    state_s = S_TRAP;
`else
               default:    state_s = fetch_or_idle_s;
`endif
            endcase
         end
         S_MEM: begin
            if (mem_ready)          state_s = (cls_r == C_LW) ? S_WB : fetch_or_idle_s;
            else if (timeout_hit_s) state_s = S_IDLE;
            else                    state_s = S_MEM;
         end
         S_WB:     state_s = fetch_or_idle_s;
         S_TRAP:   state_s = S_TRAP;
         default:  state_s = S_IDLE;
      endcase
   end

   // State, latched instruction class, wait counter and sticky timeout flag.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_r       <= S_IDLE;
         cls_r         <= C_NOP;
         wait_cnt_r    <= 8'd0;
         mem_timeout_r <= 1'b0;
      end else begin
         state_r <= state_s;
         if (state_r == S_DECODE) cls_r <= decode_class(instr[31:26]);
         else                     cls_r <= cls_r;
         if (mem_phase_s && !mem_ready && (state_s == state_r)) wait_cnt_r <= wait_cnt_r + 8'd1;
         else                                                  wait_cnt_r <= 8'd0;
         if (timeout_hit_s)                                  mem_timeout_r <= 1'b1;
         else if (state_r == S_IDLE && state_s != S_IDLE)    mem_timeout_r <= 1'b0;
         else                                                mem_timeout_r <= mem_timeout_r;
      end
   end

   // Moore output decode from state and latched class; handshake strobes qualified by mem_ready.
   always_comb begin
      ALUop         = 2'b00;
      function_code = 6'd0;
      mem_read      = 1'b0;
      mem_write     = 1'b0;
      ir_write      = 1'b0;
      pc_write      = 1'b0;
      pc_write_cond = 1'b0;
      reg_write     = 1'b0;
      alu_src       = 1'b0;
      reg_dst       = 1'b0;
      mem_to_reg    = 1'b0;
      instr_done    = 1'b0;
      case (state_r)
         S_FETCH: begin
            if (!timeout_hit_s) begin
               mem_read = 1'b1;
               ir_write = mem_ready;
               pc_write = mem_ready;
            end else begin
               mem_read = 1'b0;
            end
         end
         S_EXEC: begin
            case (cls_r)
               C_R:  begin ALUop = 2'b10; function_code = instr[5:0]; end
               C_I:  begin ALUop = 2'b11; function_code = instr[31:26]; alu_src = 1'b1; end
               C_LW, C_SW: alu_src = 1'b1;
               C_BEQ: begin ALUop = 2'b01; pc_write_cond = 1'b1; instr_done = 1'b1; end
`ifdef ILLEGAL_OP_TRAP_EN
               default: instr_done = 1'b0;
`else
               default: instr_done = 1'b1;
`endif
            endcase
         end
         S_MEM: begin
            if (!timeout_hit_s) begin
               mem_read   = (cls_r == C_LW);
               mem_write  = (cls_r == C_SW);
               instr_done = (cls_r == C_SW) && mem_ready;
            end else begin
               mem_read = 1'b0;
            end
         end
         S_WB: begin
            reg_write  = 1'b1;
            instr_done = 1'b1;
            reg_dst    = (cls_r == C_R);
            mem_to_reg = (cls_r == C_LW);
         end
         default: ALUop = 2'b00;
      endcase
   end

   assign state_out   = state_r;
   assign mem_timeout = mem_timeout_r;

endmodule
